mem_rx: RTL and testbench
=========================

Name: mem_rx

Overview:
- Receive end of the 8-bit parallel byte link the board drives on mem0..mem7 with a strobe on memF.
- The transmitter sends each 32-bit word least-significant byte first, as 4 strobed bytes.
- mem_rx samples the byte bus and strobe, reassembles 32-bit words and buffers them in a small FIFO.
- The CPU side pops words through a dmem-style read port.

Parameters:
- FIFO_DEPTH, 4, words buffered; power of two, ≥2.
- TIMEOUT, 1023, clk cycles without a strobe edge before a partial word is discarded.
- SYNC_STAGES, 2, synchroniser flops on rx_strobe and rx_data.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  external byte bus, asynchronous to clk.
- rx_strobe  input  1  external strobe; a rising edge marks a new byte.
- rd  input  1  pop the head word.
- rd_data  output  32  head word, show-ahead.
- rd_valid  output  1  FIFO not empty.
- level  output  $clog2(FIFO_DEPTH)+1  words held.
- overflow  output  1  sticky; a completed word was dropped because the FIFO was full.
- frame_err  output  1  sticky; a partial word was discarded on timeout.
- clr_err  input  1  clears overflow and frame_err.

Behaviour:
- Reset:
  - rd_valid=0, level=0, overflow=0, frame_err=0, rd_data=0.
  - Byte index=0, timeout counter=0, assembly register=0.
  - Synchroniser flops=0.
  - Reset mid-word or with a non-empty FIFO discards everything.
- Synchronisation:
  - rx_strobe and rx_data each pass through SYNC_STAGES flops, so data and strobe are delayed equally.
  - A strobe edge is synced strobe high in cycle n and low in cycle n-1.
  - The transmitter holds data stable for ≥1 clk before and ≥SYNC_STAGES+1 clk after each strobe rise.
- Assembly, on each strobe edge:
  - The synced byte is written to bits [8*idx+7:8*idx] of the assembly register.
  - idx increments mod 4.
  - The timeout counter resets to 0.
- Word completion:
  - On the edge with idx==3, the completed word (including the current byte) is pushed the same cycle.
  - idx returns to 0.
  - Latency: strobe rise at the pins to rd_valid=1 is SYNC_STAGES+2 clk.
- Timeout:
  - While idx≠0, the counter increments each cycle without an edge.
  - When it reaches TIMEOUT: idx←0, assembly register←0, frame_err←1, counter←0.
  - An edge in the timeout cycle takes priority: the byte is accepted and no error is raised.
  - While idx==0 the counter holds at 0; an idle link is not an error.
- FIFO:
  - rd_data always presents the head word.
  - rd with rd_valid=1 pops at the clock edge. rd with rd_valid=0 is ignored; no underflow flag.
  - Push when full without a simultaneous pop: the word is dropped, overflow←1, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: the pop is applied, the push succeeds, and level is unchanged.
  - Push and pop in the same cycle when empty: the push succeeds and the pop is ignored; level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags:
  - clr_err clears both sticky flags.
  - If a set condition and clr_err coincide, the set wins; flag=1.

Decomposition:
- Shared package mem_link_pkg:
  - BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4.
  - Byte order convention: LSB first. The transmitter side uses the same package.
- Sub-module word_fifo:
  - Synchronous show-ahead FIFO.
  - Parameters WIDTH and DEPTH.
  - Ports: clk, rst, push, wdata, pop, rdata, empty, full, level.
- Synchroniser, edge detect, byte counter and timeout stay in mem_rx.

Test Plan:
1. Send bytes 0x78,0x56,0x34,0x12 with 10-clk spacing -> rd_valid rises SYNC_STAGES+2 clk after the 4th strobe; rd_data=0x12345678; level=1; pop -> rd_valid=0.
2. Send 5 words 0x00000001..0x00000005 with FIFO_DEPTH=4 and no pops -> level=4, overflow=1; pops return 1,2,3,4; pulse clr_err -> overflow=0.
3. Send 2 bytes, then idle TIMEOUT clk -> frame_err=1 and rd_valid=0; then send 0xEF,0xBE,0xAD,0xDE -> rd_data=0xDEADBEEF.
4. FIFO full, hold rd=1 on the cycle the 4th byte of 0xCAFEF00D completes -> no overflow, level stays 4, and 0xCAFEF00D is the last word read.
5. Assert rst after 3 bytes of a word and with 2 words queued -> all outputs 0; the next 4 bytes 0x11,0x22,0x33,0x44 yield exactly 0x44332211.
6. Strobe held high for 20 clk and data toggling while high -> exactly one byte is captured, the value present at the rising edge.

Source files
------------

// File: rtl/mem_link_pkg.sv
// Shared definitions for the 8-bit strobed byte link (receive and transmit sides).
// Words travel least-significant byte first.
package mem_link_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx_t;

  // Place byte b into lane idx of word w, leaving the other lanes untouched.
  function automatic word_t insert_byte(word_t w, byte_idx_t idx, byte_t b);
    word_t r;
    r = w;
    r[BYTE_W*idx +: BYTE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous show-ahead FIFO. rdata presents the head word combinationally
// (zero while empty). A pop on empty is ignored; a push on full is only
// accepted when a pop frees a slot in the same cycle.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign level   = count_reg;
  assign rdata   = empty ? '0 : mem_reg[rd_ptr_reg];

  // One storage register per entry, written when the write pointer selects it.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (push_ok && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Occupancy tracks accepted pushes minus accepted pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_rx.sv
// Receive end of the strobed byte link: synchronises the byte bus and strobe,
// reassembles LSB-first 32-bit words, discards stalled partial words and
// buffers completed words for the CPU read port.
module mem_rx
  import mem_link_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BYTE_W-1:0]             rx_data,
  input  logic                          rx_strobe,
  input  logic                          rd,
  output logic [WORD_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic      strobe_sync_reg [SYNC_STAGES];
  byte_t     data_sync_reg   [SYNC_STAGES];
  logic      strobe_prev_reg;
  logic      edge_reg;
  byte_t     byte_reg;
  byte_idx_t idx_reg;
  word_t     asm_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic      overflow_reg;
  logic      frame_err_reg;

  word_t     word_next;
  logic      push_word;
  logic      timeout_hit;
  logic      fifo_empty;
  logic      fifo_full;
  logic      ovf_set;

  // Strobe and data share an identical flop chain so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        strobe_sync_reg[i] <= 1'b0;
        data_sync_reg[i]   <= '0;
      end
    end else begin
      strobe_sync_reg[0] <= rx_strobe;
      data_sync_reg[0]   <= rx_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        strobe_sync_reg[i] <= strobe_sync_reg[i-1];
        data_sync_reg[i]   <= data_sync_reg[i-1];
      end
    end
  end

  // Registered rising-edge detect; the byte is captured with the edge so a
  // strobe held high, or data moving while it is high, yields one byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_prev_reg <= 1'b0;
      edge_reg        <= 1'b0;
      byte_reg        <= '0;
    end else begin
      strobe_prev_reg <= strobe_sync_reg[SYNC_STAGES-1];
      edge_reg        <= strobe_sync_reg[SYNC_STAGES-1] & ~strobe_prev_reg;
      byte_reg        <= data_sync_reg[SYNC_STAGES-1];
    end
  end

  assign word_next   = insert_byte(asm_reg, idx_reg, byte_reg);
  assign push_word   = edge_reg && (idx_reg == byte_idx_t'(BYTES_PER_WORD-1));
  // An edge in the expiry cycle wins, so the timeout only fires without one.
  assign timeout_hit = ~edge_reg && (idx_reg != '0) && (cnt_reg == CNT_W'(TIMEOUT-1));

  // Byte lane assembly plus the stall counter that runs only mid-word.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
      asm_reg <= '0;
      cnt_reg <= '0;
    end else if (edge_reg) begin
      asm_reg <= word_next;
      idx_reg <= idx_reg + 1'b1;
      cnt_reg <= '0;
    end else if (idx_reg != '0) begin
      if (timeout_hit) begin
        idx_reg <= '0;
        asm_reg <= '0;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_word),
    .wdata (word_next),
    .pop   (rd),
    .rdata (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  // A completed word is lost only if the FIFO is full and no pop frees a slot.
  assign ovf_set = push_word & fifo_full & ~(rd & ~fifo_empty);

  // Sticky error flags; a new set event beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (ovf_set)      overflow_reg <= 1'b1;
      else if (clr_err) overflow_reg <= 1'b0;
      if (timeout_hit)  frame_err_reg <= 1'b1;
      else if (clr_err) frame_err_reg <= 1'b0;
    end
  end

  assign rd_valid  = ~fifo_empty;
  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_mem_rx.sv
// Self-checking bench for mem_rx: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_mem_rx;

  localparam int DEPTH = 4;
  localparam int TO    = 1023;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic        rd;
  logic        clr_err;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [2:0]  level;
  logic        overflow;
  logic        frame_err;

  int n_checks = 0;
  int n_err    = 0;
  bit rand_rd_en = 1'b0;

  always #5 clk = ~clk;

  mem_rx #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT     (TO),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe),
    .rd        (rd),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .level     (level),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A byte event takes effect SYNC+1 clocks after the pins first show the
  // strobe high, using the data sampled alongside that first high sample.
  logic        hs [SYNC+2];
  logic [7:0]  hd [SYNC+2];
  logic [7:0]  m_asm [4];
  logic [31:0] mq [$];
  int          m_idx;
  int          m_cnt;
  bit          m_ovf;
  bit          m_fe;

  always @(posedge clk) begin
    bit          ev, do_push, pop_ok, ovf_set, fe_set;
    logic [7:0]  b;
    logic [31:0] w;
    if (rst) begin
      mq.delete();
      m_idx = 0; m_cnt = 0; m_ovf = 0; m_fe = 0;
      m_asm = '{default: 8'h00};
      for (int i = 0; i < SYNC+2; i++) begin hs[i] = 1'b0; hd[i] = 8'h00; end
    end else begin
      ev = hs[SYNC] && !hs[SYNC+1];
      b  = hd[SYNC];
      do_push = 0; fe_set = 0; w = 32'h0;
      if (ev) begin
        m_asm[m_idx] = b;
        if (m_idx == 3) begin
          do_push = 1;
          w = {m_asm[3], m_asm[2], m_asm[1], m_asm[0]};
        end
        m_idx = (m_idx + 1) % 4;
        m_cnt = 0;
      end else if (m_idx != 0) begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_idx = 0; m_cnt = 0; fe_set = 1;
          m_asm = '{default: 8'h00};
        end
      end
      pop_ok  = rd && (mq.size() > 0);
      ovf_set = do_push && (mq.size() == DEPTH) && !pop_ok;
      if (pop_ok) $display("xfer: pop  %h", mq.pop_front());
      if (do_push && !ovf_set) begin
        mq.push_back(w);
        $display("xfer: push %h", w);
      end else if (ovf_set) begin
        $display("xfer: drop %h (fifo full)", w);
      end
      m_ovf = ovf_set ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_fe  = fe_set  ? 1'b1 : (clr_err ? 1'b0 : m_fe);
      for (int i = SYNC+1; i > 0; i--) begin hs[i] = hs[i-1]; hd[i] = hd[i-1]; end
      hs[0] = rx_strobe;
      hd[0] = rx_data;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("rd_valid",  {31'b0, rd_valid},  {31'b0, mq.size() > 0});
    check("level",     {29'b0, level},     32'(mq.size()));
    check("rd_data",   rd_data,            (mq.size() > 0) ? mq[0] : 32'h0);
    check("overflow",  {31'b0, overflow},  {31'b0, m_ovf});
    check("frame_err", {31'b0, frame_err}, {31'b0, m_fe});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_rd_en) begin
        rd      = ($urandom_range(0, 2) == 0);
        clr_err = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  task automatic send_byte(logic [7:0] b, int hi, int lo);
    rx_data = b;
    cyc(1);
    rx_strobe = 1'b1;
    cyc(hi);
    rx_strobe = 1'b0;
    cyc(lo);
  endtask

  task automatic send_word(logic [31:0] w, int hi, int lo);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], hi, lo);
  endtask

  task automatic pop_expect(string name, logic [31:0] exp);
    check({name, "_valid"}, {31'b0, rd_valid}, 32'h1);
    check(name, rd_data, exp);
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
  endtask

  // ---------------- directed and random scenarios ----------------
  initial begin
    int lat;
    logic [31:0] rw;
    rst = 1'b1; rx_data = 8'h00; rx_strobe = 1'b0; rd = 1'b0; clr_err = 1'b0;
    cyc(3);
    rst = 1'b0;
    check("reset_valid", {31'b0, rd_valid}, 32'h0);
    check("reset_level", {29'b0, level}, 32'h0);
    check("reset_data", rd_data, 32'h0);
    check("reset_ovf", {31'b0, overflow}, 32'h0);
    check("reset_ferr", {31'b0, frame_err}, 32'h0);

    // 1: single word, latency and pop
    send_byte(8'h78, 4, 5);
    send_byte(8'h56, 4, 5);
    send_byte(8'h34, 4, 5);
    rx_data = 8'h12;
    cyc(1);
    rx_strobe = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (rd_valid) begin lat = n; break; end
    end
    check("latency", 32'(lat), 32'(SYNC + 2));
    cyc(6);
    rx_strobe = 1'b0;
    cyc(3);
    check("t1_level", {29'b0, level}, 32'h1);
    pop_expect("t1_word", 32'h12345678);
    check("t1_empty", {31'b0, rd_valid}, 32'h0);

    // 2: overflow with five words into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_word(32'(i), 4, 2);
    cyc(8);
    check("t2_level", {29'b0, level}, 32'h4);
    check("t2_ovf", {31'b0, overflow}, 32'h1);
    for (int i = 1; i <= 4; i++) pop_expect("t2_word", 32'(i));
    pulse_clr();
    check("t2_ovf_clr", {31'b0, overflow}, 32'h0);

    // 3: partial word timeout, then a clean word
    send_byte(8'hAA, 4, 2);
    send_byte(8'hBB, 4, 2);
    cyc(TO + 10);
    check("t3_ferr", {31'b0, frame_err}, 32'h1);
    check("t3_valid", {31'b0, rd_valid}, 32'h0);
    send_word(32'hDEADBEEF, 4, 2);
    cyc(8);
    pop_expect("t3_word", 32'hDEADBEEF);
    pulse_clr();

    // 3b: second byte lands one before, exactly on, and one after expiry
    for (int d = -1; d <= 1; d++) begin
      send_byte(8'h10, 4, TO - 5 + d);
      send_byte(8'h20, 4, 4);
      check("to_edge_ferr", {31'b0, frame_err}, (d == 1) ? 32'h1 : 32'h0);
      cyc(TO + 10);
      pulse_clr();
    end

    // 4: full FIFO, pop coincides with completion of the fifth word
    for (int i = 0; i < 4; i++) send_word(32'hA0 + 32'(i), 4, 2);
    cyc(8);
    check("t4_full", {29'b0, level}, 32'h4);
    send_byte(8'h0D, 4, 2);
    send_byte(8'hF0, 4, 2);
    send_byte(8'hFE, 4, 2);
    rx_data = 8'hCA;
    cyc(1);
    rx_strobe = 1'b1;
    cyc(SYNC + 1);
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    check("t4_level", {29'b0, level}, 32'h4);
    check("t4_ovf", {31'b0, overflow}, 32'h0);
    cyc(2);
    rx_strobe = 1'b0;
    cyc(3);
    pop_expect("t4_w1", 32'hA1);
    pop_expect("t4_w2", 32'hA2);
    pop_expect("t4_w3", 32'hA3);
    pop_expect("t4_last", 32'hCAFEF00D);

    // 5: reset mid-word with words queued
    send_word(32'h0BADF00D, 4, 2);
    send_word(32'h00C0FFEE, 4, 2);
    send_byte(8'h99, 4, 2);
    send_byte(8'h98, 4, 2);
    send_byte(8'h97, 4, 2);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    check("t5_valid", {31'b0, rd_valid}, 32'h0);
    check("t5_level", {29'b0, level}, 32'h0);
    check("t5_data", rd_data, 32'h0);
    send_word(32'h44332211, 4, 2);
    cyc(8);
    check("t5_level1", {29'b0, level}, 32'h1);
    pop_expect("t5_word", 32'h44332211);

    // 6: long strobe with data moving while high
    rx_data = 8'hA5;
    cyc(1);
    rx_strobe = 1'b1;
    cyc(SYNC + 1);
    for (int i = 0; i < 20 - (SYNC + 1); i++) begin
      rx_data = 8'($urandom);
      cyc(1);
    end
    rx_strobe = 1'b0;
    cyc(2);
    send_byte(8'h01, 4, 2);
    send_byte(8'h02, 4, 2);
    send_byte(8'h03, 4, 2);
    cyc(8);
    check("t6_level", {29'b0, level}, 32'h1);
    pop_expect("t6_word", 32'h030201A5);

    // Random traffic with random pops and clears
    pulse_clr();
    rand_rd_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rw = $urandom;
      send_word(rw, $urandom_range(3, 6), $urandom_range(1, 4));
    end
    rand_rd_en = 1'b0;
    rd = 1'b0;
    clr_err = 1'b0;
    cyc(20);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (rd_valid) begin
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
      end
    end
    cyc(2);
    check("drain_empty", {31'b0, rd_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
